// File: rtl/fmap_stream_source.sv
// Frame-RAM backed pixel streamer: replays a stored IMG_WIDTH x IMG_HEIGHT frame in
// raster order, then appends FLUSH_LEN zero beats to drain a downstream 3x3 window.
module fmap_stream_source #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_WIDTH  = 56,
    parameter int IMG_HEIGHT = 56,
    parameter int ADDR_W     = 12,
    parameter int FLUSH_LEN  = IMG_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  start,
    input  logic                  hold,
    output logic                  stream_valid,
    output logic [DATA_WIDTH-1:0] stream_data,
    output logic                  stream_last,
    output logic                  busy,
    output logic                  done
);

    localparam int NPIX  = IMG_WIDTH * IMG_HEIGHT;
    localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;

    localparam logic [ADDR_W:0] NPIX_C    = (ADDR_W + 1)'(NPIX);
    localparam logic [ADDR_W:0] LAST_PTR  = (ADDR_W + 1)'(NPIX - 1);
    localparam logic [ADDR_W:0] FLUSH_CNT = (ADDR_W + 1)'(FLUSH_LEN);
    localparam logic [ADDR_W:0] ONE_C     = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        STREAM = 3'd1,
        FLUSH  = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_t;

    logic [DATA_WIDTH-1:0] mem [NPIX];

    state_t                state_q, state_d;
    logic [ADDR_W:0]       ptr_q, ptr_d;
    logic [ADDR_W:0]       flush_cnt_q, flush_cnt_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  last_q, last_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  wr_ok_s;
    logic [DATA_WIDTH-1:0] rd_word_s;

    // The frame may only be rewritten while idle, and only inside the image.
    assign wr_ok_s   = wr_en && (state_q == IDLE) && ({1'b0, wr_addr} < NPIX_C);
    assign rd_word_s = mem[ptr_q[IDX_W-1:0]];

    // Frame RAM write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem[wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

    // Next-state, pointer/counter and next-beat computation.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        flush_cnt_d = flush_cnt_q;
        valid_d     = 1'b0;
        data_d      = '0;
        last_d      = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = STREAM;
                    ptr_d       = '0;
                    flush_cnt_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            STREAM: begin
                if (!hold) begin
                    valid_d = 1'b1;
                    data_d  = rd_word_s;
                    ptr_d   = ptr_q + ONE_C;
                    if (ptr_q == LAST_PTR) begin
                        last_d  = 1'b1;
                        state_d = (FLUSH_CNT == '0) ? DRAIN : FLUSH;
                    end else begin
                        state_d = STREAM;
                    end
                end else begin
                    state_d = STREAM;
                end
            end
            FLUSH: begin
                if (!hold) begin
                    valid_d     = 1'b1;
                    flush_cnt_d = flush_cnt_q + ONE_C;
                    if (flush_cnt_d == FLUSH_CNT) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = FLUSH;
                    end
                end else begin
                    state_d = FLUSH;
                end
            end
            // The last issued beat is on the outputs during this cycle.
            DRAIN: begin
                state_d = DONE;
                done_d  = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, counters and registered stream outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            flush_cnt_q <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            flush_cnt_q <= flush_cnt_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign stream_valid = valid_q;
    assign stream_data  = data_q;
    assign stream_last  = last_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_fmap_stream_source.sv
// Directed bench for fmap_stream_source on a 4x3 frame: one DUT with FLUSH_LEN=5 and
// one with FLUSH_LEN=0 share all inputs; frames run back-to-back from a vector table.
module tb_fmap_stream_source;

    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          start;
    logic          hold;
    logic          sv, sl, busy, done;
    logic [DW-1:0] sd;
    logic          sv0, sl0, busy0, done0;
    logic [DW-1:0] sd0;

    always #5 clk = ~clk;

    fmap_stream_source #(.DATA_WIDTH(DW), .IMG_WIDTH(4), .IMG_HEIGHT(3), .ADDR_W(AW), .FLUSH_LEN(5)) dut (
        .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .hold(hold), .stream_valid(sv), .stream_data(sd), .stream_last(sl),
        .busy(busy), .done(done));

    fmap_stream_source #(.DATA_WIDTH(DW), .IMG_WIDTH(4), .IMG_HEIGHT(3), .ADDR_W(AW), .FLUSH_LEN(0)) dut0 (
        .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .hold(hold), .stream_valid(sv0), .stream_data(sd0), .stream_last(sl0),
        .busy(busy0), .done(done0));

    typedef struct {
        int hs1, hl1, hs2, hl2, inj;
        int exp_done, exp_gaps, exp_done0;
    } vec_t;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] pix [12];
    logic [31:0] beats [40];
    int nb, last_at, first_c, last_vc, done_c, ndone, bad, busy_after;
    int nb0, last0, done0_c, bad0;
    int tot_beats, tot_done;

    function automatic logic [31:0] exp_beat(input int i);
        return (i < 12) ? pix[i] : 32'h0000_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts a frame in the current cycle and observes both DUTs until done plus one cycle.
    task automatic run_frame(input int hs1, input int hl1, input int hs2, input int hl2, input int inj);
        int k;
        nb = 0; last_at = -1; first_c = -1; last_vc = -1; done_c = -1; ndone = 0; bad = 0;
        nb0 = 0; last0 = -1; done0_c = -1; bad0 = 0;
        start = 1'b1;
        hold  = 1'b0;
        k = 0;
        while (done_c < 0 && k < 60) begin
            step();
            k++;
            start = 1'b0;
            wr_en = 1'b0;
            if (sv) begin
                if (nb < 40) beats[nb] = sd;
                if (sl) last_at = nb;
                if (first_c < 0) first_c = k;
                last_vc = k;
                nb++;
            end else if (sd != 32'h0 || sl) begin
                bad++;
            end
            if (done) begin
                ndone++;
                done_c = k;
            end
            if (sv0) begin
                if (sd0 != exp_beat(nb0)) bad0++;
                if (sl0) last0 = nb0;
                nb0++;
            end else if (sd0 != 32'h0 || sl0) begin
                bad0++;
            end
            if (done0) done0_c = k;
            hold = ((k >= hs1) && (k < hs1 + hl1)) || ((k >= hs2) && (k < hs2 + hl2));
            if (k == inj) begin
                wr_en   = 1'b1;
                wr_addr = 4'd3;
                wr_data = 32'hdead_beef;
                start   = 1'b1;
            end
        end
        hold = 1'b0;
        step();
        if (done) ndone++;
        if (sv) nb++;
        busy_after = busy;
    endtask

    task automatic check_frame(input string tag, input vec_t v);
        chk({tag, " done_seen"}, (done_c >= 0), 1'b1);
        chk({tag, " beat_count"}, nb, 17);
        for (int i = 0; i < 17; i++) begin
            if (i < nb) chk($sformatf("%s beat%0d", tag, i), beats[i], exp_beat(i));
        end
        chk({tag, " last_index"}, last_at, 11);
        chk({tag, " first_valid_cycle"}, first_c, 2);
        chk({tag, " done_cycle"}, done_c, v.exp_done);
        chk({tag, " gap_cycles"}, last_vc - first_c + 1 - nb, v.exp_gaps);
        chk({tag, " zero_when_invalid"}, bad, 0);
        chk({tag, " done_pulses"}, ndone, 1);
        chk({tag, " busy_after_done"}, busy_after, 0);
        chk({tag, " f0 beat_count"}, nb0, 12);
        chk({tag, " f0 last_index"}, last0, 11);
        chk({tag, " f0 done_cycle"}, done0_c, v.exp_done0);
        chk({tag, " f0 data"}, bad0, 0);
    endtask

    vec_t tbl [4];

    initial begin
        int cnt;
        pix[0] = 32'h3f80_0000; pix[1]  = 32'h4000_0000; pix[2]  = 32'h4040_0000;
        pix[3] = 32'h4080_0000; pix[4]  = 32'h40a0_0000; pix[5]  = 32'h40c0_0000;
        pix[6] = 32'h40e0_0000; pix[7]  = 32'h4100_0000; pix[8]  = 32'h4110_0000;
        pix[9] = 32'h4120_0000; pix[10] = 32'h4130_0000; pix[11] = 32'h4140_0000;

        //            hs1 hl1 hs2 hl2 inj done gaps done0
        tbl[0] = '{0,  0,  0,  0,  0,  19,  0,   14};
        tbl[1] = '{5,  3,  17, 2,  0,  24,  5,   17};
        tbl[2] = '{0,  0,  0,  0,  6,  19,  0,   14};
        tbl[3] = '{0,  0,  0,  0,  0,  19,  0,   14};

        resetn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; hold = 1'b0;
        repeat (3) step();
        chk("reset valid", sv, 0);
        chk("reset data", sd, 0);
        chk("reset busy_done", {busy, done, sl}, 0);
        resetn = 1'b1;
        step();

        for (int a = 0; a < 11; a++) begin
            wr_en = 1'b1; wr_addr = AW'(a); wr_data = pix[a];
            step();
        end
        wr_addr = 4'd12; wr_data = 32'h1234_5678;
        step();
        // Final pixel written in the same cycle as start.
        wr_addr = 4'd11; wr_data = pix[11];

        tot_beats = 0;
        tot_done  = 0;
        for (int r = 0; r < 4; r++) begin
            run_frame(tbl[r].hs1, tbl[r].hl1, tbl[r].hs2, tbl[r].hl2, tbl[r].inj);
            check_frame($sformatf("vec%0d", r), tbl[r]);
            if (r >= 2) begin
                tot_beats += nb;
                tot_done  += ndone;
            end
        end
        chk("b2b beat_total", tot_beats, 34);
        chk("b2b done_total", tot_done, 2);

        // Abort after the seventh beat, then replay from pixel 0.
        start = 1'b1;
        cnt = 0;
        for (int k = 0; k < 20 && cnt < 7; k++) begin
            step();
            start = 1'b0;
            if (sv) cnt++;
        end
        chk("abort reached_beat7", cnt, 7);
        resetn = 1'b0;
        #1;
        chk("abort outputs", {sv, sl, busy, done}, 0);
        chk("abort data", sd, 0);
        chk("abort f0 outputs", {sv0, sl0, busy0, done0}, 0);
        step();
        resetn = 1'b1;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (sv || busy) cnt++;
        end
        chk("abort quiet", cnt, 0);
        run_frame(0, 0, 0, 0, 0);
        check_frame("replay", tbl[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fmap_stream_source.md
FMAP_STREAM_SOURCE -- requirements
Module: fmap_stream_source

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, default 32: pixel word width (FP32).
- IMG_WIDTH, default 56: pixels per row.
- IMG_HEIGHT, default 56: rows per frame.
- ADDR_W, default 12: frame-RAM address width; ADDR_W SHALL satisfy 2^ADDR_W >= IMG_WIDTH*IMG_HEIGHT.
- FLUSH_LEN, default IMG_WIDTH+1: zero beats appended after the frame to drain a downstream 3x3 line-buffer window.

REQ-002 Ports SHALL be:
- clk  in  1  clock; all logic on rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- wr_en  in  1  frame-RAM write strobe.
- wr_addr  in  ADDR_W  write address, raster index row*IMG_WIDTH+col.
- wr_data  in  DATA_WIDTH  write data.
- start  in  1  single-cycle request to stream the stored frame.
- hold  in  1  stall; no beat is issued in a cycle where hold=1.
- stream_valid  out  1  beat qualifier, driven directly into a conv data_valid_in.
- stream_data  out  DATA_WIDTH  beat data.
- stream_last  out  1  high with the final image pixel, not with flush beats.
- busy  out  1  high while a frame or flush is in progress.
- done  out  1  one-cycle completion pulse.

Function
REQ-003 The block SHALL hold an IMG_WIDTH*IMG_HEIGHT x DATA_WIDTH RAM with a synchronous read of 1-cycle latency.
REQ-004 The FSM SHALL have the states IDLE, STREAM, FLUSH, DRAIN, DONE.
REQ-005 In IDLE:
- wr_en=1 SHALL write wr_data to wr_addr.
- wr_addr >= IMG_WIDTH*IMG_HEIGHT SHALL be ignored.
REQ-006 In any non-IDLE state, wr_en SHALL be ignored and the RAM SHALL be unchanged.
REQ-007 start=1 sampled in IDLE SHALL move the FSM to STREAM with read pointer 0; start SHALL be ignored in all other states.
REQ-008 start and wr_en in the same IDLE cycle SHALL both take effect; that write precedes the first read.
REQ-009 Each STREAM cycle with hold=0 SHALL:
- issue a read of the pointer and increment it;
- produce stream_valid=1 with the RAM word on the next cycle.
REQ-010 A STREAM or FLUSH cycle with hold=1 SHALL issue nothing, keep the pointer and counters, and give stream_valid=0 on the next cycle.
REQ-011 stream_data SHALL be 0 whenever stream_valid=0.
REQ-012 Issuing address IMG_WIDTH*IMG_HEIGHT-1 SHALL set stream_last=1 on the following cycle.
REQ-013 Also on issuing that address, the FSM SHALL move to FLUSH, or to DRAIN if FLUSH_LEN=0.
REQ-014 In FLUSH, each hold=0 cycle SHALL issue one zero beat, so the next cycle gives stream_valid=1 and stream_data=0.
REQ-015 After FLUSH_LEN such beats, the FSM SHALL move to DRAIN.
REQ-016 DRAIN SHALL last one cycle, in which the final beat is on the outputs, then move to DONE.
REQ-017 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-018 hold SHALL have no effect in DRAIN, DONE or IDLE.
REQ-019 busy SHALL be 1 in STREAM, FLUSH, DRAIN and DONE, and 0 in IDLE.
REQ-020 Beats SHALL leave in raster order: row 0 col 0..IMG_WIDTH-1, then row 1, and so on, with no beat duplicated or dropped under any hold pattern.
REQ-021 Latency SHALL be 2 cycles from the start sample to the first stream_valid when hold=0.
REQ-022 The total beat count per frame SHALL be exactly IMG_WIDTH*IMG_HEIGHT+FLUSH_LEN.
REQ-023 Pointer and beat counters SHALL be ADDR_W+1 bits and SHALL never wrap within a frame.
REQ-024 A second start is legal in the cycle after done, and SHALL replay the unchanged RAM identically.

Reset
REQ-025 resetn=0 SHALL, asynchronously:
- set the FSM to IDLE and clear the pointer and counters;
- drive stream_valid, stream_data, stream_last, busy and done to 0.
REQ-026 RAM contents SHALL NOT be cleared by reset.
REQ-027 Reset mid-STREAM or mid-FLUSH SHALL abort the frame with no further beats. A subsequent start SHALL stream from pixel 0 using the retained RAM contents.

Verification
Parameters for all scenarios: IMG_WIDTH=4, IMG_HEIGHT=3, FLUSH_LEN=5.
REQ-028 Basic frame:
- write 1.0..12.0 (32'h3f800000..) to addresses 0..11, start, hold=0;
- expect 12 beats in order from cycle start+2, stream_last on the 12th;
- then 5 zero beats, done one cycle after the 17th beat, busy low the cycle after done.
REQ-029 Stall:
- hold=1 for 3 cycles during pixel 5 and for 2 cycles during flush;
- expect a 3-cycle and a 2-cycle gap in stream_valid, beats still 1..12 then 5 zeros, done at cycle start+2+17+5.
REQ-030 Ignored inputs:
- wr_en to address 3 mid-stream, and start asserted while busy;
- expect RAM and beats unaffected, exactly one done.
REQ-031 Back-to-back:
- start again the cycle after done;
- expect an identical 17-beat sequence, with beat count 34 and done count 2 over both frames.
REQ-032 Reset abort:
- resetn low for 1 cycle after beat 7;
- expect all outputs 0 immediately and no further beats; a new start streams 1.0..12.0 from pixel 0.
REQ-033 FLUSH_LEN=0 variant:
- expect exactly 12 beats, stream_last on beat 12, done one cycle later.
